// File: rtl/mem_rd_stream.sv
// Burst reader: streams num_items words from base_addr via a 2-entry FIFO; first word 3 cycles after start, then 1/cycle.
// Reads issue only when FIFO space is guaranteed (ready_in low stalls issue). MEM_RD_STREAM_STRIDE_EN adds a stride port.

module mem_rd_stream_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic [W-1:0] head_dat,
  output logic         head_vld,
  output logic [1:0]   cnt
);

  logic [W-1:0] tail_dat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_dat <= '0;
      tail_dat <= '0;
      cnt      <= '0;
    end else begin
      case ({push_vld, pop_rdy})
        2'b10: begin
          if (cnt == 2'd0) head_dat <= push_dat;
          else             tail_dat <= push_dat;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head_dat <= tail_dat;
          cnt      <= cnt - 2'd1;
        end
        2'b11: begin
          // count unchanged; the new word goes behind whatever remains
          if (cnt == 2'd1) begin
            head_dat <= push_dat;
          end else begin
            head_dat <= tail_dat;
            tail_dat <= push_dat;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_vld = (cnt != 2'd0);

endmodule

module mem_rd_stream #(
  parameter int DATA_WIDTH      = 8,
  parameter int LOG_MAX_ADDRESS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LOG_MAX_ADDRESS-1:0] base_addr,
  input  logic [LOG_MAX_ADDRESS:0]   num_items,
`ifdef MEM_RD_STREAM_STRIDE_EN
  input  logic [LOG_MAX_ADDRESS-1:0] stride,
`endif
  output logic                       busy,
  output logic                       done,
  output logic [LOG_MAX_ADDRESS-1:0] mem_addr_read,
  output logic                       mem_read,
  input  logic [DATA_WIDTH-1:0]      mem_data_read,
  input  logic                       mem_valid_out,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       valid_out,
  input  logic                       ready_in
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                     state;
  logic [LOG_MAX_ADDRESS-1:0] addr_q;
  logic [LOG_MAX_ADDRESS-1:0] step;
  logic [LOG_MAX_ADDRESS:0]   remaining;
  logic                       in_flight;
  logic [1:0]                 fifo_cnt;
  logic [1:0]                 occ;
  logic                       pop;
  logic                       push;
  logic                       issue;
  logic                       drained;

`ifdef MEM_RD_STREAM_STRIDE_EN
  logic [LOG_MAX_ADDRESS-1:0] stride_q;

  always_ff @(posedge clk) begin
    if (!rst)                                               stride_q <= '0;
    else if (state == IDLE && start && num_items != '0)     stride_q <= stride;
  end

  assign step = stride_q;
`else
  assign step = LOG_MAX_ADDRESS'(1);
`endif

  assign pop  = valid_out && ready_in;
  assign push = mem_valid_out && in_flight;
  assign occ  = fifo_cnt + {1'b0, in_flight};

  // Issue is decoded from registered state plus the current pop so a slot
  // freed this cycle is reused at once, sustaining 1 word/cycle with 2 entries.
  assign issue    = (state == RUN) && (remaining != '0) && ((occ < 2'd2) || pop);
  assign mem_read = issue;
  assign mem_addr_read = addr_q;

  assign drained = !in_flight && ((fifo_cnt == 2'd0) || (fifo_cnt == 2'd1 && pop));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      remaining <= '0;
      in_flight <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      in_flight <= issue;
      case (state)
        IDLE: begin
          if (start) begin
            if (num_items == '0) begin
              done <= 1'b1;
            end else begin
              addr_q    <= base_addr;
              remaining <= num_items;
              busy      <= 1'b1;
              state     <= RUN;
            end
          end
        end
        RUN: begin
          if (issue) begin
            addr_q    <= addr_q + step;
            remaining <= remaining - 1'b1;
            if (remaining == (LOG_MAX_ADDRESS+1)'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drained) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_rd_stream_fifo #(.W(DATA_WIDTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push),
    .push_dat (mem_data_read),
    .pop_rdy  (pop),
    .head_dat (data_out),
    .head_vld (valid_out),
    .cnt      (fifo_cnt)
  );

endmodule
